// File: rtl/inst_decoder.sv
// Registered RV32I instruction decoder: raw field slices, sign-extended immediate,
// one-hot format class and illegal-opcode flag. Define DECODER_INSTOUT_EN to add instOut.
module inst_decoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] instIn,
  output logic            out_valid,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      fn3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      fn7,
  output logic [XLEN-1:0] imm,
  output logic [5:0]      fmt,
  output logic            illegal
`ifdef DECODER_INSTOUT_EN
  ,
  output logic [XLEN-1:0] instOut
`endif
);

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  logic [5:0]      fmt_d;
  logic [XLEN-1:0] imm_d;
  logic            illegal_d;

  // Shift-immediates need no special case: their imm is the plain I-type field.
  always_comb begin
    fmt_d     = 6'b0;
    imm_d     = '0;
    illegal_d = 1'b0;
    case (instIn[6:0])
      7'h33: fmt_d = FMT_R;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
        fmt_d = FMT_I;
        imm_d = {{20{instIn[31]}}, instIn[31:20]};
      end
      7'h23: begin
        fmt_d = FMT_S;
        imm_d = {{20{instIn[31]}}, instIn[31:25], instIn[11:7]};
      end
      7'h63: begin
        fmt_d = FMT_B;
        imm_d = {{19{instIn[31]}}, instIn[31], instIn[7], instIn[30:25], instIn[11:8], 1'b0};
      end
      7'h37, 7'h17: begin
        fmt_d = FMT_U;
        imm_d = {instIn[31:12], 12'b0};
      end
      7'h6F: begin
        fmt_d = FMT_J;
        imm_d = {{11{instIn[31]}}, instIn[31], instIn[19:12], instIn[20], instIn[30:21], 1'b0};
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      opcode    <= '0;
      rd        <= '0;
      fn3       <= '0;
      rs1       <= '0;
      rs2       <= '0;
      fn7       <= '0;
      imm       <= '0;
      fmt       <= '0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= inst_valid;
      if (inst_valid) begin
        opcode  <= instIn[6:0];
        rd      <= instIn[11:7];
        fn3     <= instIn[14:12];
        rs1     <= instIn[19:15];
        rs2     <= instIn[24:20];
        fn7     <= instIn[31:25];
        imm     <= imm_d;
        fmt     <= fmt_d;
        illegal <= illegal_d;
      end
    end
  end

`ifdef DECODER_INSTOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instOut <= '0;
    else if (inst_valid) instOut <= instIn;
  end
`endif

endmodule

// File: tb/tb_inst_decoder.sv
// Self-checking bench for inst_decoder: directed vector table, hand-written reset/hold
// sequences and randomized instructions against a behavioural RV32I decode model.
module tb_inst_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] instIn = '0;
  logic        out_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  fn3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  fn7;
  logic [31:0] imm;
  logic [5:0]  fmt;
  logic        illegal;
`ifdef DECODER_INSTOUT_EN
  logic [31:0] instOut;
`endif

  inst_decoder #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .instIn(instIn),
    .out_valid(out_valid), .opcode(opcode), .rd(rd), .fn3(fn3), .rs1(rs1),
    .rs2(rs2), .fn7(fn7), .imm(imm), .fmt(fmt), .illegal(illegal)
`ifdef DECODER_INSTOUT_EN
    , .instOut(instOut)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [5:0]  fmt;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  fmt;
    logic [31:0] imm;
    logic        illegal;
  } vec_t;

  exp_t exp_s;

  // Reference decode from the ISA rules, using arithmetic on the whole word.
  function automatic exp_t model(input logic [31:0] inst, input logic valid);
    exp_t e;
    logic [31:0] sgn;
    int unsigned u;
    u = inst;
    sgn = inst[31] ? 32'hFFFF_FFFF : 32'h0;
    e.valid = valid;
    e.inst = inst;
    e.imm = 32'h0;
    e.fmt = 6'h0;
    e.illegal = 1'b0;
    case (u % 128)
      'h33: e.fmt = 6'd1;
      'h13, 'h03, 'h67, 'h73, 'h0F: begin
        e.fmt = 6'd2;
        e.imm = (sgn << 12) | (u / 1048576);
      end
      'h23: begin
        e.fmt = 6'd4;
        e.imm = (sgn << 12) | ((u / 33554432) * 32) | ((u / 128) % 32);
      end
      'h63: begin
        e.fmt = 6'd8;
        e.imm = (sgn << 12) | (((u / 128) % 2) * 2048) | (((u / 33554432) % 64) * 32)
              | (((u / 256) % 16) * 2);
      end
      'h37, 'h17: begin
        e.fmt = 6'd16;
        e.imm = u - (u % 4096);
      end
      'h6F: begin
        e.fmt = 6'd32;
        e.imm = (sgn << 20) | (((u / 4096) % 256) * 4096) | (((u / 1048576) % 2) * 2048)
              | (((u / 2097152) % 1024) * 2);
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compares every output against the expected registered state.
  task automatic check_all(input string tag);
    cmp({tag, ".out_valid"}, 32'(out_valid), 32'(exp_s.valid));
    cmp({tag, ".opcode"}, 32'(opcode), 32'(exp_s.inst % 128));
    cmp({tag, ".rd"}, 32'(rd), (exp_s.inst / 128) % 32);
    cmp({tag, ".fn3"}, 32'(fn3), (exp_s.inst / 4096) % 8);
    cmp({tag, ".rs1"}, 32'(rs1), (exp_s.inst / 32768) % 32);
    cmp({tag, ".rs2"}, 32'(rs2), (exp_s.inst / 1048576) % 32);
    cmp({tag, ".fn7"}, 32'(fn7), exp_s.inst / 33554432);
    cmp({tag, ".imm"}, imm, exp_s.imm);
    cmp({tag, ".fmt"}, 32'(fmt), 32'(exp_s.fmt));
    cmp({tag, ".illegal"}, 32'(illegal), 32'(exp_s.illegal));
`ifdef DECODER_INSTOUT_EN
    cmp({tag, ".instOut"}, instOut, exp_s.inst);
`endif
  endtask

  task automatic step(input logic v, input logic [31:0] inst);
    exp_t m;
    @(negedge clk);
    inst_valid = v;
    instIn = inst;
    @(posedge clk);
    #1;
    m = model(inst, v);
    if (v) exp_s = m;
    else exp_s.valid = 1'b0;
  endtask

  task automatic clear_exp();
    exp_s.valid = 1'b0;
    exp_s.inst = '0;
    exp_s.imm = '0;
    exp_s.fmt = '0;
    exp_s.illegal = 1'b0;
  endtask

  vec_t vecs[14];
  logic [6:0] legal_ops[11];

  initial begin
    vecs[0]  = '{32'h00848933, 6'd1,  32'h00000000, 1'b0};
    vecs[1]  = '{32'h10100493, 6'd2,  32'd257,      1'b0};
    vecs[2]  = '{32'h41425313, 6'd2,  32'h00000414, 1'b0};
    vecs[3]  = '{32'h0082a223, 6'd4,  32'd4,        1'b0};
    vecs[4]  = '{32'h0002a303, 6'd2,  32'd0,        1'b0};
    vecs[5]  = '{32'h014c6463, 6'd8,  32'd8,        1'b0};
    vecs[6]  = '{32'h7ff080e7, 6'd2,  32'd2047,     1'b0};
    vecs[7]  = '{32'h0000006f, 6'd32, 32'd0,        1'b0};
    vecs[8]  = '{32'h872370b7, 6'd16, 32'h87237000, 1'b0};
    vecs[9]  = '{32'h10000917, 6'd16, 32'h10000000, 1'b0};
    vecs[10] = '{32'h0000007F, 6'd0,  32'd0,        1'b1};
    vecs[11] = '{32'hfff00093, 6'd2,  32'hFFFFFFFF, 1'b0};
    vecs[12] = '{32'hfe000ee3, 6'd8,  32'hFFFFFFFC, 1'b0};
    vecs[13] = '{32'hffdff06f, 6'd32, 32'hFFFFFFFC, 1'b0};
    legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    clear_exp();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: constants from the ISA encoding, plus model cross-check.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].inst);
      cmp($sformatf("tbl%0d.imm", i), imm, vecs[i].imm);
      cmp($sformatf("tbl%0d.fmt", i), 32'(fmt), 32'(vecs[i].fmt));
      cmp($sformatf("tbl%0d.illegal", i), 32'(illegal), 32'(vecs[i].illegal));
      check_all($sformatf("tbl%0d", i));
    end

    // Hold: a new instruction without valid must not disturb the registers.
    step(1'b1, 32'h41425313);
    step(1'b0, 32'h872370b7);
    check_all("hold");
    cmp("hold.imm_const", imm, 32'h00000414);
    step(1'b1, 32'h872370b7);
    check_all("after_hold");

    // Asynchronous reset mid-cycle, no clock edge involved.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    inst_valid = 1'b0;
    step(1'b0, 32'h00848933);
    check_all("post_reset_idle");
    step(1'b1, 32'h00848933);
    check_all("post_reset_r");
    cmp("post_reset_r.rd", 32'(rd), 32'd18);
    cmp("post_reset_r.rs1", 32'(rs1), 32'd9);
    cmp("post_reset_r.rs2", 32'(rs2), 32'd8);

    // Randomized: mostly legal opcodes, some raw words, random valid gaps.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] r;
      logic v;
      r = $urandom();
      if ($urandom_range(0, 3) != 0) r[6:0] = legal_ops[$urandom_range(0, 10)];
      v = ($urandom_range(0, 4) != 0);
      step(v, r);
      check_all($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
